regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with per-register scoreboard. Holds DEPTH registers of WIDTH bits, each with a busy bit. Provides two combinational read ports (A, B), one clocked write port, and one clocked reserve port. Sits between the instruction decoder (reserves destination registers at issue) and the ALU/bus writeback path (writes data and releases the reservation). It is the generalised successor to the fixed 16x16-bit register file.

## Interface
Parameters:
- WIDTH, 16, data width of each register (>= 1).
- DEPTH, 16, number of registers; must equal 2**SELW.
- SELW, 4, selector width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- wen, in, 1, write enable.
- selW, in, SELW, write destination index.
- bus, in, WIDTH, write data.
- rsv, in, 1, reserve strobe; marks register selRsv busy.
- selRsv, in, SELW, reserve index.
- selA, in, SELW, read port A index.
- selB, in, SELW, read port B index.
- a, out, WIDTH, contents of register selA.
- b, out, WIDTH, contents of register selB.
- busyA, out, 1, busy bit of register selA.
- busyB, out, 1, busy bit of register selB.
- nbusy, out, SELW+1, count of busy registers (0..DEPTH).
- err, out, 1, sticky reservation-conflict flag.

## Operation
- State: regs[DEPTH] (WIDTH bits each), busy[DEPTH], err.
- Reads are combinational and independent: a = regs[selA], b = regs[selB]; selA == selB is legal.
- Write: on a clock edge with wen=1, regs[selW] <= bus and busy[selW] <= 0. Writing a non-busy register is legal and does not affect err.
- Reserve: on a clock edge with rsv=1, busy[selRsv] <= 1.
- Same edge, wen=1, rsv=1, selW == selRsv: the data is written and busy ends at 1. Reserve wins, so the old write retires and the new one is pending.
- Conflict: rsv=1 targeting a register that is busy, and not released by wen on the same edge, sets err <= 1. The reservation is still applied, so busy stays 1. err is cleared only by rst.
- nbusy is the combinational popcount of busy[]; it reflects registered state only.
- All registers are readable and writable; there is no hardwired-zero register.

## Timing
- Reset (async, immediate): regs all 0, busy all 0, err 0. Resulting outputs: a = b = 0, busyA = busyB = 0, nbusy = 0.
- Reset asserted mid-operation discards all pending reservations and data. The first edge after rst deasserts behaves as from cold.
- Read latency: 0 cycles (combinational from selA/selB and state).
- Write latency: 1 cycle. Data written at edge N is visible on a/b after edge N, subject to the bypass configuration.
- Busy set/clear latency: 1 cycle. nbusy and err update after the edge.
- Simultaneous wen and rsv to different indices: both take effect on the same edge. nbusy changes by 0 net if the written register was busy.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If wen=1 and selW == selA, then a = bus in the same cycle and busyA = (rsv && selRsv == selA). Port B behaves identically.
  - nbusy and err are not bypassed.
- REGFILE_BYPASS_EN undefined: a and b always show registered contents, and busyA/busyB show registered busy bits. New data and cleared busy appear the cycle after the write edge.

## Test plan
- Reset: write several registers, then pulse rst asynchronously between edges. Required: a, b, busyA, busyB, nbusy, err all 0 immediately, and all registers read 0 afterwards.
- Write/read all: write value 16'hA500+i to register i for i = 0..15 (default parameters). Required: after each edge, reading any index on A and B returns its value, including selA == selB.
- Scoreboard: rsv r3, then rsv r7. Required: nbusy = 2 and busyA = 1 for selA = 3. Then wen r3 with 16'h1234. Required: busy[3] = 0, nbusy = 1, a = 16'h1234.
- Same-index collision: r5 busy; on one edge wen r5 16'h00FF together with rsv r5. Required: regs[5] = 16'h00FF, busy[5] = 1, err = 0. Then rsv r5 alone. Required: err = 1, staying 1 until rst.
- Bypass: with selA = selW = 2, wen = 1, bus = 16'hBEEF, check a before the edge. Required: 16'hBEEF with REGFILE_BYPASS_EN defined, old value without it. Both builds read 16'hBEEF after the edge.
- Parameter sweep: WIDTH = 8, DEPTH = 4, SELW = 2. Reserve all 4 registers. Required: nbusy = 4. Write index 3 with 8'hFF. Required: a = 8'hFF, nbusy = 3, and no aliasing into the other indices.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: groups the decoder/writeback-facing signals of regfile_sb.
// The master modport belongs to the side driving selects, write and reserve.
// The slave modport belongs to the register file itself.
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 4
);
  logic              wen;
  logic [SELW-1:0]   selW;
  logic [WIDTH-1:0]  bus;
  logic              rsv;
  logic [SELW-1:0]   selRsv;
  logic [SELW-1:0]   selA;
  logic [SELW-1:0]   selB;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busyA;
  logic              busyB;
  logic [SELW:0]     nbusy;
  logic              err;

  modport master (
    output wen, selW, bus, rsv, selRsv, selA, selB,
    input  a, b, busyA, busyB, nbusy, err
  );

  modport slave (
    input  wen, selW, bus, rsv, selRsv, selA, selB,
    output a, b, busyA, busyB, nbusy, err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file with a per-register busy scoreboard.
// Two combinational read ports, one clocked write port (which also releases
// the busy bit), and one clocked reserve port (which sets it).
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data and the
// resulting busy bit onto the read ports.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int SELW  = 4
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave rf
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        err_q, err_d;
  logic [SELW:0]               nbusy_c;

  // Next state: write releases, reserve then sets, so reserve wins on a tie.
  // A reservation onto a register still busy after this edge's release is a conflict.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (rf.wen) begin
      regs_d[rf.selW] = rf.bus;
      busy_d[rf.selW] = 1'b0;
    end
    if (rf.rsv) begin
      if (busy_q[rf.selRsv] && !(rf.wen && (rf.selW == rf.selRsv)))
        err_d = 1'b1;
      busy_d[rf.selRsv] = 1'b1;
    end
  end

  // State registers; reset drops all data and pending reservations at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Busy count from registered state only (never bypassed).
  always_comb begin
    nbusy_c = '0;
    for (int i = 0; i < DEPTH; i++)
      nbusy_c = nbusy_c + (SELW+1)'(busy_q[i]);
  end

  // Read ports: registered contents, optionally overridden by the in-flight write.
  always_comb begin
    rf.a     = regs_q[rf.selA];
    rf.b     = regs_q[rf.selB];
    rf.busyA = busy_q[rf.selA];
    rf.busyB = busy_q[rf.selB];
`ifdef REGFILE_BYPASS_EN
    if (rf.wen && (rf.selW == rf.selA)) begin
      rf.a     = rf.bus;
      rf.busyA = rf.rsv && (rf.selRsv == rf.selA);
    end
    if (rf.wen && (rf.selW == rf.selB)) begin
      rf.b     = rf.bus;
      rf.busyB = rf.rsv && (rf.selRsv == rf.selB);
    end
`endif
  end

  // Status outputs.
  always_comb begin
    rf.nbusy = nbusy_c;
    rf.err   = err_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed + random checks of regfile_sb against an array model.
// Main instance uses default parameters; a second 8x4 instance covers the sweep.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(16), .SELW(4)) ifa ();
  regfile_sb_if #(.WIDTH(8),  .SELW(2)) ifs ();

  regfile_sb #(.WIDTH(16), .DEPTH(16), .SELW(4)) dut (.clk(clk), .rst(rst), .rf(ifa));
  regfile_sb #(.WIDTH(8),  .DEPTH(4),  .SELW(2)) dut_s (.clk(clk), .rst(rst), .rf(ifs));

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: plain arrays plus a sticky flag.
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // What a read port should show for index sel given the current inputs.
  task automatic exp_rd(input logic [3:0] sel, output logic [15:0] d, output logic bz);
    d  = m_regs[sel];
    bz = m_busy[sel];
    if (BYP && ifa.wen && ifa.selW == sel) begin
      d  = ifa.bus;
      bz = ifa.rsv && (ifa.selRsv == sel);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] ea, eb;
    logic        ba, bb;
    int          n;
    exp_rd(ifa.selA, ea, ba);
    exp_rd(ifa.selB, eb, bb);
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    chk({tag, ".a"},     32'(ifa.a),     32'(ea));
    chk({tag, ".b"},     32'(ifa.b),     32'(eb));
    chk({tag, ".busyA"}, 32'(ifa.busyA), 32'(ba));
    chk({tag, ".busyB"}, 32'(ifa.busyB), 32'(bb));
    chk({tag, ".nbusy"}, 32'(ifa.nbusy), n);
    chk({tag, ".err"},   32'(ifa.err),   32'(m_err));
  endtask

  // Advance one edge; the model consumes the inputs held across that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifa.rsv && m_busy[ifa.selRsv] && !(ifa.wen && ifa.selW == ifa.selRsv)) m_err = 1'b1;
    if (ifa.wen) begin
      m_regs[ifa.selW] = ifa.bus;
      m_busy[ifa.selW] = 1'b0;
    end
    if (ifa.rsv) m_busy[ifa.selRsv] = 1'b1;
  endtask

  task automatic idle();
    ifa.wen = 1'b0; ifa.rsv = 1'b0; ifa.selW = '0; ifa.selRsv = '0; ifa.bus = '0;
    ifs.wen = 1'b0; ifs.rsv = 1'b0; ifs.selW = '0; ifs.selRsv = '0; ifs.bus = '0;
    ifs.selA = '0; ifs.selB = '0;
  endtask

  task automatic drive(input bit w, input logic [3:0] sw, input logic [15:0] d,
                       input bit r, input logic [3:0] sr,
                       input logic [3:0] sa, input logic [3:0] sb);
    ifa.wen = w; ifa.selW = sw; ifa.bus = d;
    ifa.rsv = r; ifa.selRsv = sr;
    ifa.selA = sa; ifa.selB = sb;
  endtask

  // Asynchronous pulse between edges; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    idle();
    chk({tag, ".a"},     32'(ifa.a),     0);
    chk({tag, ".b"},     32'(ifa.b),     0);
    chk({tag, ".busyA"}, 32'(ifa.busyA), 0);
    chk({tag, ".busyB"}, 32'(ifa.busyB), 0);
    chk({tag, ".nbusy"}, 32'(ifa.nbusy), 0);
    chk({tag, ".err"},   32'(ifa.err),   0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ifa.selA = '0; ifa.selB = '0;
    model_clear();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    #1;
    check_all("cold_reset");

    // Reset mid-operation: dirty a few registers and an error, then pulse rst.
    drive(1, 4'd1, 16'h1111, 1, 4'd9, 4'd1, 4'd9); tick();
    drive(0, 4'd0, 16'h0,    1, 4'd9, 4'd1, 4'd9); tick();
    check_all("pre_reset");
    pulse_reset("async_reset");
    for (int i = 0; i < 16; i++) begin
      drive(0, 4'd0, 16'h0, 0, 4'd0, 4'(i), 4'(15 - i));
      #1;
      check_all("post_reset_read");
    end

    // Write/read all registers.
    for (int i = 0; i < 16; i++) begin
      drive(1, 4'(i), 16'hA500 + 16'(i), 0, 4'd0, 4'(i), 4'(i));
      tick();
      drive(0, 4'd0, 16'h0, 0, 4'd0, 4'(i), 4'($urandom_range(0, i)));
      #1;
      check_all("write_all");
      chk("write_all.direct", 32'(ifa.a), 32'(16'hA500 + 16'(i)));
    end

    // Scoreboard: reserve r3 and r7, then release r3.
    drive(0, 4'd0, 16'h0, 1, 4'd3, 4'd3, 4'd7); tick();
    drive(0, 4'd0, 16'h0, 1, 4'd7, 4'd3, 4'd7); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd7); #1;
    chk("sb.nbusy2", 32'(ifa.nbusy), 2);
    chk("sb.busyA3", 32'(ifa.busyA), 1);
    check_all("sb.reserved");
    drive(1, 4'd3, 16'h1234, 0, 4'd0, 4'd3, 4'd7); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd7); #1;
    chk("sb.a1234",  32'(ifa.a),     32'h1234);
    chk("sb.busy3",  32'(ifa.busyA), 0);
    chk("sb.nbusy1", 32'(ifa.nbusy), 1);

    // Same-index collision on r5, then a true conflict.
    drive(0, 4'd0, 16'h0, 1, 4'd5, 4'd5, 4'd5); tick();
    drive(1, 4'd5, 16'h00FF, 1, 4'd5, 4'd5, 4'd5); #1;
    check_all("coll.pre");
    tick();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd5, 4'd3); #1;
    chk("coll.data", 32'(ifa.a),     32'h00FF);
    chk("coll.busy", 32'(ifa.busyA), 1);
    chk("coll.err0", 32'(ifa.err),   0);
    drive(0, 4'd0, 16'h0, 1, 4'd5, 4'd5, 4'd3); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd5, 4'd3); #1;
    chk("coll.err1", 32'(ifa.err), 1);
    tick(); tick();
    chk("coll.sticky", 32'(ifa.err), 1);
    check_all("coll.post");

    // Bypass on r2.
    drive(1, 4'd2, 16'hBEEF, 0, 4'd0, 4'd2, 4'd2); #1;
    chk("byp.pre", 32'(ifa.a), BYP ? 32'hBEEF : 32'hA502);
    check_all("byp.pre_all");
    tick();
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd2, 4'd2); #1;
    chk("byp.post", 32'(ifa.a), 32'hBEEF);

    // Random traffic against the model, with one reset in the middle.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom), 4'($urandom));
      #1;
      check_all("rand");
      tick();
      if (c == 200) begin
        chk("rand.err_before_reset", 32'(ifa.err), 32'(m_err));
        pulse_reset("rand_reset");
      end
    end
    drive(0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd1); #1;
    check_all("rand.final");

    // Parameter sweep instance: 8-bit x 4.
    for (int i = 0; i < 4; i++) begin
      ifs.rsv = 1'b1; ifs.selRsv = 2'(i);
      @(posedge clk); #1;
    end
    ifs.rsv = 1'b0;
    #1;
    chk("sweep.nbusy4", 32'(ifs.nbusy), 4);
    ifs.wen = 1'b1; ifs.selW = 2'd3; ifs.bus = 8'hFF;
    @(posedge clk); #1;
    ifs.wen = 1'b0; ifs.selA = 2'd3;
    #1;
    chk("sweep.a", 32'(ifs.a), 32'hFF);
    chk("sweep.nbusy3", 32'(ifs.nbusy), 3);
    for (int i = 0; i < 3; i++) begin
      ifs.selB = 2'(i);
      #1;
      chk("sweep.noalias", 32'(ifs.b), 0);
      chk("sweep.busy", 32'(ifs.busyB), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
